mav_input_cond: RTL and testbench
=================================

Name: mav_input_cond

Overview:
- Upstream input conditioner for the moving-average unit. Takes a raw push-button and raw slide-switch word from the board.
- Synchronises both inputs and debounces the button.
- Emits a one-cycle `en` strobe together with a registered `d` sample, matching the MAV sampling interface. MAV captures `d` on any clock edge where `en` is high.
- Also keeps a wrapping count of accepted samples for display and debug.

Parameters:
- DW, 16: data width of `sw` and `d`.
- DB_CYCLES, 4: consecutive stable synchronised cycles required to accept a press or a release. Legal range is at least 2.
- CW, 8: width of the `sample_cnt` output.
- REPEAT_CYCLES, 16: auto-repeat period in cycles. Used only with `MAV_INPUT_COND_REPEAT_EN`.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  1  raw push-button, asynchronous, bouncy.
- sw  in  DW  raw switch word, asynchronous.
- en  out  1  one-cycle sample strobe to MAV.
- d  out  DW  sample data, valid whenever `en`=1.
- busy  out  1  high while FSM ≠ IDLE.
- sample_cnt  out  CW  number of `en` pulses issued, wraps modulo 2^CW.

Behaviour:
- Reset is asynchronous, active-high. One clock (`clk`), rising edge.
- Reset values:
  - `en`=0, `d`=0, `busy`=0, `sample_cnt`=0.
  - Sync flops 0, debounce counter 0, FSM=IDLE.
- Reset asserted mid-operation clears everything immediately. No `en` pulse is generated for a press in progress.
- Synchronisers: `btn` and `sw` each pass through a 2-flop chain. Internal `btn_s` and `sw_s` are the second-stage outputs.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. The debounce counter width is $clog2(DB_CYCLES).
- IDLE:
  - `btn_s`=1 → PRESS_WAIT, cnt=1.
  - Otherwise stay, cnt=0.
- PRESS_WAIT:
  - `btn_s`=0 → IDLE, cnt=0. This is the bounce-reject path.
  - `btn_s`=1 and cnt==DB_CYCLES-1 → HELD, cnt=0. On the same edge: `en`<=1, `d`<=`sw_s`, `sample_cnt`<=`sample_cnt`+1.
  - Otherwise cnt++.
- HELD: `btn_s`=0 → RELEASE_WAIT, cnt=1.
- RELEASE_WAIT:
  - `btn_s`=1 → HELD, cnt=0. A release bounce produces no new pulse.
  - `btn_s`=0 and cnt==DB_CYCLES-1 → IDLE.
  - Otherwise cnt++.
- `en` is registered and is high for exactly one cycle per accepted press.
- `d` holds its value between pulses. It changes only on the edge that raises `en`.
- Latency: count the first edge that samples `btn`=1 as edge 1. With a clean press, `en` goes high after edge DB_CYCLES+2 (edge 6 for the defaults).
- `sw` changes after the pulse do not affect `d` until the next accepted press.
- `sample_cnt` wraps from 2^CW-1 to 0 with no flag.
- `busy` = (state ≠ IDLE), registered with the state.
- A press shorter than DB_CYCLES synchronised cycles produces no pulse and no count change.

Optional Feature:
- Macro: `MAV_INPUT_COND_REPEAT_EN`.
- Defined:
  - In HELD, a repeat counter increments each cycle. It is cleared on entry to HELD and on each repeat pulse.
  - When it reaches REPEAT_CYCLES-1, the block issues another `en` pulse with `d`<=current `sw_s` and `sample_cnt`++.
  - The repeat counter is cleared in every other state.
- Undefined:
  - Exactly one pulse per press, however long the hold.
  - The repeat counter and REPEAT_CYCLES logic are absent.

Decomposition:
- Shared package `mav_pkg`:
  - FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), 2-bit encoding.
  - Default DW=16, shared with MAV.
- One natural sub-module: `sync2`, a parameterised-width 2-flop synchroniser with async active-high reset. It is instantiated twice, for `btn` (width 1) and for `sw` (width DW).

Test Plan:
1. Reset: assert `rst` mid-press (in PRESS_WAIT). Required: `en`=0, `d`=0, `busy`=0 and `sample_cnt`=0 immediately, with no clock edge needed; no pulse after release of reset.
2. Clean press: `sw`=16'h0005, `btn` held high 20 cycles. Required: `en`=1 for exactly one cycle after edge 6, `d`=16'h0005, `sample_cnt`=1, `busy`=1 until 4 cycles after `btn_s` falls.
3. Bounce reject: `btn` toggles 1,0,1,0 each cycle, then stays low. Required: no `en` pulse, `sample_cnt` stays 0, FSM returns to IDLE.
4. Release bounce: while in HELD, `btn` goes 0 for 2 cycles, then 1, then low permanently. Required: only one `en` pulse in total; IDLE is reached 4 cycles after the final `btn_s` falling edge.
5. Data hold and wrap: presses with `sw` = 16'h0001, 16'h0002, 16'h0003, changing `sw` between presses. Required: `d` follows each value only at its pulse. With CW=2, the fourth press shows `sample_cnt` 3→0.
6. With the macro defined, REPEAT_CYCLES=8: hold `btn` 40 cycles. Required: first pulse at edge 6, then one pulse every 8 cycles while held.

Source files
------------

// File: rtl/mav_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mav_pkg                                                            |
// | Shared types and defaults for the moving-average unit and its      |
// | input conditioner.                                                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mav_pkg;

  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync2                                                              |
// | Parameterised-width two-flop synchroniser, async active-high reset.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/mav_input_cond.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mav_input_cond                                                     |
// | Synchronises and debounces a push-button and samples the switch    |
// | word, emitting a one-cycle en strobe with registered d for MAV.    |
// | Optional auto-repeat while held: MAV_INPUT_COND_REPEAT_EN.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mav_input_cond
  import mav_pkg::*;
#(
  parameter int DW            = DW_DEFAULT,
  parameter int DB_CYCLES     = 4,
  parameter int CW            = 8,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic [DW-1:0] sw,
  output logic          en,
  output logic [DW-1:0] d,
  output logic          busy,
  output logic [CW-1:0] sample_cnt
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  if (DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("mav_input_cond: DB_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  logic          w_btn_s;
  logic [DW-1:0] w_sw_s;

  sync2 #(.W(1)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .i_d (btn),
    .o_q (w_btn_s)
  );

  sync2 #(.W(DW)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .i_d (sw),
    .o_q (w_sw_s)
  );

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_en;
  logic [DW-1:0]   r_d;
  logic            r_busy;
  logic [CW-1:0]   r_sample_cnt;

`ifdef MAV_INPUT_COND_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] c_RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_en         <= 1'b0;
      r_d          <= '0;
      r_busy       <= 1'b0;
      r_sample_cnt <= '0;
`ifdef MAV_INPUT_COND_REPEAT_EN
      r_rpt        <= '0;
`endif
    end else begin
      r_en <= 1'b0;
`ifdef MAV_INPUT_COND_REPEAT_EN
      // Cleared outside HELD so every entry to HELD starts a fresh period.
      r_rpt <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_btn_s) begin
            r_state <= ST_PRESS_WAIT;
            r_busy  <= 1'b1;
            r_cnt   <= c_CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_btn_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state      <= ST_HELD;
            r_cnt        <= '0;
            r_en         <= 1'b1;
            r_d          <= w_sw_s;
            r_sample_cnt <= r_sample_cnt + CW'(1);
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!w_btn_s) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= c_CNT_ONE;
          end
`ifdef MAV_INPUT_COND_REPEAT_EN
          else if (r_rpt == c_RPT_LAST) begin
            r_en         <= 1'b1;
            r_d          <= w_sw_s;
            r_sample_cnt <= r_sample_cnt + CW'(1);
          end else begin
            r_rpt <= r_rpt + RPT_W'(1);
          end
`endif
        end
        ST_RELEASE_WAIT: begin
          if (w_btn_s) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign en         = r_en;
  assign d          = r_d;
  assign busy       = r_busy;
  assign sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mav_input_cond.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mav_input_cond                                                  |
// | Directed self-checking bench with a level/run-length model.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mav_input_cond;

  localparam int DW = 16;
  localparam int DB = 4;
  localparam int CW = 2;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b0;
  logic [DW-1:0] sw  = '0;
  logic          en;
  logic [DW-1:0] d;
  logic          busy;
  logic [CW-1:0] sample_cnt;

  mav_input_cond #(
    .DW(DW), .DB_CYCLES(DB), .CW(CW), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw),
    .en(en), .d(d), .busy(busy), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int pulses = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: the button has a debounced level and a count of consecutive
  // samples disagreeing with it; DB disagreeing samples flip the level.
  bit            mb1, mb2, m_s, m_en, m_level;
  logic [DW-1:0] ms1, ms2, m_sws, m_d;
  int            m_run, m_hold, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb1 = 0; mb2 = 0; ms1 = '0; ms2 = '0;
      m_en = 0; m_level = 0; m_d = '0; m_run = 0; m_hold = 0; m_cnt = 0;
    end else begin
      m_s = mb2; m_sws = ms2;
      mb2 = mb1; ms2 = ms1;
      mb1 = btn; ms1 = sw;
      m_en = 0;
      if (m_s != m_level) begin
        m_run++;
        m_hold = 0;
        if (m_run == DB) begin
          m_level = m_s;
          m_run = 0;
          if (m_s) begin
            m_en = 1; m_d = m_sws; m_cnt = (m_cnt + 1) % (1 << CW);
          end
        end
      end else if (m_run > 0) begin
        m_run = 0;
        m_hold = 0;
      end else if (m_level) begin
`ifdef MAV_INPUT_COND_REPEAT_EN
        if (m_hold == RC - 1) begin
          m_hold = 0;
          m_en = 1; m_d = m_sws; m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_hold++;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      chk("en", en, m_en);
      chk("d", d, m_d);
      chk("busy", busy, m_level || (m_run > 0));
      chk("sample_cnt", sample_cnt, m_cnt);
      if (en) pulses++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int edges[$];
  logic [DW-1:0] vals [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
  int cnt_exp [4] = '{2, 3, 0, 1};

  initial begin
    cycles(3);
    chk("rst_en", en, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;

    // Clean press: edge 1 is the first edge sampling btn=1.
    sw = 16'h0005;
    cycles(3);
    btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) chk("clean_en_e5", en, 0);
      if (k == 6) begin
        chk("clean_en_e6", en, 1);
        chk("clean_d_e6", d, 16'h0005);
`ifndef MAV_INPUT_COND_REPEAT_EN
        chk("clean_cnt_e6", sample_cnt, 1);
`endif
      end
      if (k == 7) chk("clean_en_e7", en, 0);
      if (k == 20) btn = 1'b0;
      if (k == 25) chk("clean_busy_e25", busy, 1);
      if (k == 26) chk("clean_busy_e26", busy, 0);
    end

    // Reset in the middle of a press.
    cycles(2);
    btn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midpress_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_en", en, 0);
    chk("async_rst_d", d, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", sample_cnt, 0);
    @(negedge clk);
    btn = 1'b0;
    cycles(3);
    rst = 1'b0;
    pulses = 0;
    cycles(12);
    chk("post_rst_pulses", pulses, 0);

    // Press bounce rejected.
    pulses = 0;
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(10);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_cnt", sample_cnt, 0);
    chk("bounce_busy", busy, 0);

    // Release bounce yields a single pulse.
    sw = 16'h00AA;
    cycles(2);
    pulses = 0;
    btn = 1'b1; cycles(10);
    btn = 1'b0; cycles(2);
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(12);
    chk("relbounce_pulses", pulses, 1);
    chk("relbounce_d", d, 16'h00AA);
    chk("relbounce_cnt", sample_cnt, 1);
    chk("relbounce_busy", busy, 0);

    // Data hold between presses and counter wrap.
    for (int i = 0; i < 4; i++) begin
      sw = vals[i];
      cycles(3);
      btn = 1'b1; cycles(8);
      btn = 1'b0; cycles(3);
      sw = vals[i] + 16'h0100;
      cycles(8);
      chk("hold_d", d, vals[i]);
      chk("wrap_cnt", sample_cnt, cnt_exp[i]);
    end

`ifdef MAV_INPUT_COND_REPEAT_EN
    // Auto-repeat during a 40-cycle hold.
    sw = 16'h0077;
    cycles(4);
    btn = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (en) edges.push_back(k);
      if (k == 40) btn = 1'b0;
    end
    chk("rpt_count", edges.size(), 5);
    if (edges.size() == 5) begin
      chk("rpt_first", edges[0], 6);
      chk("rpt_second", edges[1], 14);
      chk("rpt_last", edges[4], 38);
    end
`endif

    cycles(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
